// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
// Counter-width helper keeps every counter at least one bit wide.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_GAP   = 2;

    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Word handshake plus serial/debug outputs of the pattern transmitter.
// master = stimulus side, slave = transmitter side.
interface serial_pattern_tx_if #(
    parameter int WIDTH = serial_pkg::DEF_WIDTH
);
    logic [WIDTH-1:0] Data;
    logic             Start;
    logic             Ready;
    logic             w;
    logic             Active;
    logic             Done;
    logic [1:0]       CurState;

    modport master (
        output Data, Start,
        input  Ready, w, Active, Done, CurState
    );

    modport slave (
        input  Data, Start,
        output Ready, w, Active, Done, CurState
    );
endinterface

// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial pattern source, MSB first, GAP zero cycles per word; first bit one cycle after accept.
// Ready only in IDLE or the frame-end cycle, so back-to-back words stream with no bubble.
module serial_pattern_tx
    import serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GAP   = DEF_GAP
) (
    input  logic               Clock,
    input  logic               Resetn,
    serial_pattern_tx_if.slave bus
);

    localparam int              CW       = cnt_bits(WIDTH);
    localparam int              GW       = cnt_bits(GAP + 1);
    localparam bit              HAS_GAP  = (GAP > 0);
    localparam logic [CW-1:0]   BIT_LOAD = CW'(WIDTH - 1);
    localparam logic [GW-1:0]   GAP_LOAD = GW'((GAP > 0) ? (GAP - 1) : 0);

    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_bit_cnt;
    logic [GW-1:0]    r_gap_cnt;

    logic w_last_bit;
    logic w_gap_end;
    logic w_frame_end;
    logic w_ready;
    logic w_accept;

    assign w_last_bit  = (r_state == SHIFT) && (r_bit_cnt == '0);
    assign w_gap_end   = (r_state == serial_pkg::GAP) && (r_gap_cnt == '0);
    // With no guard cycles the last data bit doubles as the frame end.
    assign w_frame_end = (w_last_bit && !HAS_GAP) || w_gap_end;
    assign w_ready     = (r_state == IDLE) || w_frame_end;
    assign w_accept    = bus.Start && w_ready;

    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE: begin
                w_state_nxt = w_accept ? SHIFT : IDLE;
            end
            SHIFT: begin
                if (!w_last_bit) begin
                    w_state_nxt = SHIFT;
                end else if (HAS_GAP) begin
                    w_state_nxt = serial_pkg::GAP;
                end else begin
                    w_state_nxt = w_accept ? SHIFT : IDLE;
                end
            end
            serial_pkg::GAP: begin
                if (!w_gap_end) begin
                    w_state_nxt = serial_pkg::GAP;
                end else begin
                    w_state_nxt = w_accept ? SHIFT : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept) begin
                r_shift   <= bus.Data;
                r_bit_cnt <= BIT_LOAD;
            end else if (r_state == SHIFT) begin
                r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                if (!w_last_bit) begin
                    r_bit_cnt <= r_bit_cnt - 1'b1;
                end
            end

            if (w_last_bit && HAS_GAP) begin
                r_gap_cnt <= GAP_LOAD;
            end else if ((r_state == serial_pkg::GAP) && !w_gap_end) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
        end
    end

    assign bus.Ready    = w_ready;
    assign bus.w        = (r_state == SHIFT) && r_shift[WIDTH-1];
    assign bus.Active   = (r_state == SHIFT);
    assign bus.Done     = w_last_bit;
    assign bus.CurState = r_state;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: one instance with GAP=2, one with GAP=0, cycle-accurate
// expected outputs queued as each cycle's stimulus is driven.
module tb_serial_pattern_tx;
    import serial_pkg::*;

    typedef struct {
        logic       start;
        logic [7:0] data;
        logic       w;
        logic       act;
        logic       done;
        logic       rdy;
        logic [1:0] st;
    } vec_t;

    logic Clock  = 1'b0;
    logic rstn_a = 1'b0;
    logic rstn_b = 1'b0;

    int   n_assert = 0;
    int   n_fail   = 0;
    vec_t sb[$];
    vec_t t2[12];

    always #5 Clock = ~Clock;

    serial_pattern_tx_if #(.WIDTH(8)) bus_a ();
    serial_pattern_tx_if #(.WIDTH(8)) bus_b ();

    serial_pattern_tx #(.WIDTH(8), .GAP(2)) dut_a (
        .Clock  (Clock),
        .Resetn (rstn_a),
        .bus    (bus_a.slave)
    );

    serial_pattern_tx #(.WIDTH(8), .GAP(0)) dut_b (
        .Clock  (Clock),
        .Resetn (rstn_b),
        .bus    (bus_b.slave)
    );

    function automatic vec_t mk(input logic s, input logic [7:0] d, input logic ew,
                                input logic ea, input logic ed, input logic er,
                                input logic [1:0] es);
        vec_t v;
        v.start = s;
        v.data  = d;
        v.w     = ew;
        v.act   = ea;
        v.done  = ed;
        v.rdy   = er;
        v.st    = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input int sel, input string tag, input vec_t e);
        logic       ow, oa, od, orr;
        logic [1:0] os;
        if (sel == 0) begin
            ow = bus_a.w; oa = bus_a.Active; od = bus_a.Done; orr = bus_a.Ready; os = bus_a.CurState;
        end else begin
            ow = bus_b.w; oa = bus_b.Active; od = bus_b.Done; orr = bus_b.Ready; os = bus_b.CurState;
        end
        check({tag, ".w"},      {7'd0, ow},  {7'd0, e.w});
        check({tag, ".active"}, {7'd0, oa},  {7'd0, e.act});
        check({tag, ".done"},   {7'd0, od},  {7'd0, e.done});
        check({tag, ".ready"},  {7'd0, orr}, {7'd0, e.rdy});
        check({tag, ".state"},  {6'd0, os},  {6'd0, e.st});
    endtask

    // One cycle: drive inputs for the coming edge, then compare this cycle's outputs.
    task automatic apply(input int sel, input vec_t v, input string tag);
        vec_t e;
        @(negedge Clock);
        if (sel == 0) begin
            bus_a.Start = v.start;
            bus_a.Data  = v.data;
        end else begin
            bus_b.Start = v.start;
            bus_b.Data  = v.data;
        end
        sb.push_back(v);
        #1;
        e = sb.pop_front();
        check_outs(sel, tag, e);
    endtask

    // Whole word on the GAP=2 instance; inj>0 pulses Start with Data=0 at that data bit.
    task automatic word_seq(input int sel, input logic [7:0] data, input int gap,
                            input int inj, input string tag);
        logic [7:0] d;
        d = data;
        apply(sel, mk(1'b1, data, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0), {tag, ".c0"});
        for (int k = 1; k <= 8; k++) begin
            if (inj != 0 && k >= inj) d = 8'h00;
            apply(sel, mk((k == inj), d, data[8-k], 1'b1, (k == 8), (k == 8 && gap == 0), 2'd1),
                  $sformatf("%s.c%0d", tag, k));
        end
        for (int g = 1; g <= gap; g++) begin
            apply(sel, mk(1'b0, d, 1'b0, 1'b0, 1'b0, (g == gap), 2'd2),
                  $sformatf("%s.g%0d", tag, g));
        end
        apply(sel, mk(1'b0, d, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0), {tag, ".idle"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        bus_a.Start = 1'b0; bus_a.Data = 8'h00;
        bus_b.Start = 1'b0; bus_b.Data = 8'h00;

        // B4 = 1011_0100 on the GAP=2 instance
        t2[0]  = mk(1'b1, 8'hB4, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        t2[1]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
        t2[2]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
        t2[3]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
        t2[4]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
        t2[5]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
        t2[6]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
        t2[7]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
        t2[8]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        t2[9]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        t2[10] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
        t2[11] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);

        // Reset state
        repeat (2) @(negedge Clock);
        rstn_a = 1'b1;
        rstn_b = 1'b1;
        #1;
        check_outs(0, "t1.a", mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
        check_outs(1, "t1.b", mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));

        for (int i = 0; i < 12; i++) begin
            apply(0, t2[i], $sformatf("t2.c%0d", i));
        end

        // GAP=0 streaming of three FF words with Start held high
        apply(1, mk(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0), "t3.c0");
        for (int k = 1; k <= 24; k++) begin
            apply(1, mk((k != 24), 8'hFF, 1'b1, 1'b1, (k % 8 == 0), (k % 8 == 0), 2'd1),
                  $sformatf("t3.c%0d", k));
        end
        apply(1, mk(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0), "t3.idle");

        // Start/Data changes mid-word are ignored
        word_seq(0, 8'hF0, 2, 3, "t4");

        // Asynchronous reset during bit 4
        apply(0, mk(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0), "t5.c0");
        for (int k = 1; k <= 3; k++) begin
            apply(0, mk(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1), $sformatf("t5.c%0d", k));
        end
        @(negedge Clock);
        #1;
        check("t5.bit4.w", {7'd0, bus_a.w}, 8'd1);
        #1;
        rstn_a = 1'b0;
        #1;
        check_outs(0, "t5.rst", mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
        @(negedge Clock);
        rstn_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            apply(0, mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0), $sformatf("t5.post%0d", k));
        end
        word_seq(0, 8'h5A, 2, 0, "t5w");

        // Illegal state encoding recovers to IDLE
        @(negedge Clock);
        force dut_a.r_state = tx_state_t'(2'd3);
        #1;
        check("t6.forced.state", {6'd0, bus_a.CurState}, 8'd3);
        check("t6.forced.w", {7'd0, bus_a.w}, 8'd0);
        #2;
        release dut_a.r_state;
        apply(0, mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0), "t6.recover");
        word_seq(0, 8'hC3, 2, 0, "t6w");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
